axi_uart_rx_parity: RTL and testbench

AXI_UART_RX_PARITY -- requirements
Module: axi_uart_rx_parity

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/axi_uart_rx_parity.sv | 149 ++++++++++++++
 tb/tb_axi_uart_rx_parity.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the parity-carrying UART receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int TDATA_W   = DATA_BITS + 1;
    localparam int BITCNT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/axi_uart_rx_parity.sv
// UART receiver (8 data + parity + stop) presenting {parity, data} on a
// single-entry AXI-Stream output register.
module axi_uart_rx_parity
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] clkdiv,
    input  logic                 rx,
    output logic [TDATA_W-1:0]   o_tdata,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    output logic                 framing_error,
    output logic                 overrun
);

    rx_state_e              state_q, state_d;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic [BITCNT_W-1:0]    bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic [TDATA_W-1:0]     tdata_q;
    logic                   tvalid_q;
    logic                   ferr_q;
    logic                   ovr_q;

    logic                   tick;
    logic                   start_edge;
    logic                   sample_en;
    logic                   shift_en;
    logic                   par_en;
    logic                   frame_done;
    logic                   frame_bad;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    assign tick       = (cnt_q == '0);
    assign start_edge = rx_prev_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_edge) state_d = ST_START;
            ST_START:  if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && bit_q == BITCNT_W'(DATA_BITS - 1)) state_d = ST_PARITY;
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) state_d = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_en  = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            ST_START:  sample_en = tick;
            ST_DATA: begin
                sample_en = tick;
                shift_en  = tick;
            end
            ST_PARITY: begin
                sample_en = tick;
                par_en    = tick;
            end
            ST_STOP: begin
                sample_en  = tick;
                frame_done = tick & rx_s;
                frame_bad  = tick & ~rx_s;
            end
            default: ;
        endcase
    end

    // Bit timing: first sample half a bit after the start edge, then one per latched divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q <= 1'b1;
            div_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
        end else begin
            rx_prev_q <= rx_s;
            if (state_q == ST_IDLE) begin
                if (start_edge) begin
                    div_q <= clkdiv;
                    cnt_q <= clkdiv >> 1;
                    bit_q <= '0;
                end
            end else if (sample_en) begin
                cnt_q <= div_q - DIV_WIDTH'(1);
                if (shift_en) bit_q <= bit_q + BITCNT_W'(1);
            end else if (!tick) begin
                cnt_q <= cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        if (par_en)   par_q   <= rx_s;
    end

    // Output slot: a new frame may replace the word only if the slot is empty or draining now.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ferr_q <= frame_bad;
            ovr_q  <= frame_done & tvalid_q & ~o_tready;
            if (frame_done && (!tvalid_q || o_tready)) begin
                tdata_q  <= {par_q, shift_q};
                tvalid_q <= 1'b1;
            end else if (tvalid_q && o_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign o_tdata       = tdata_q;
    assign o_tvalid      = tvalid_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_axi_uart_rx_parity.sv
// Scoreboard bench for axi_uart_rx_parity: serial frames are generated from
// a byte/parity/stop description and the expected words queued for a monitor.
module tb_axi_uart_rx_parity;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] clkdiv = 16'd16;
    logic          rx = 1'b1;
    logic [8:0]    o_tdata;
    logic          o_tvalid;
    logic          o_tready;
    logic          framing_error;
    logic          overrun;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vcyc   = 0;
    int         rdy_mode = 1;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_data  = '0;
    logic [8:0] mon_exp;

    always #5 clk = ~clk;

    axi_uart_rx_parity #(.DIV_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .clkdiv        (clkdiv),
        .rx            (rx),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    // Ready driver: 0 = stalled, 1 = always ready, otherwise random backpressure.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       o_tready = 1'b0;
                1:       o_tready = 1'b1;
                default: o_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (framing_error) fe_cnt++;
            if (overrun)       ov_cnt++;
            if (o_tvalid)      vcyc++;
            if (prev_stall) begin
                check("hold_valid", int'(o_tvalid), 1);
                check("hold_data", int'(o_tdata), int'(prev_data));
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat: got unexpected word 0x%03h expected none", o_tdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", int'(o_tdata), int'(mon_exp));
                end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, parity, stop; each bit lasts div cycles.
    task automatic send_frame(input int div, input logic [7:0] d, input logic p,
                              input logic stop, input bit expect_out, input bit wiggle);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        if (expect_out) exp_q.push_back({p, d});
        clkdiv = DW'(div);
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (wiggle && i == 0 && c == div - 1) clkdiv = DW'($urandom_range(4, 40));
            end
        end
        if (stop) rx = 1'b1;
    endtask

    int          f0, v0, o0, div;
    logic [7:0]  rd;
    logic        rp;
    logic [10:0] partial;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        idle(4);
        check("rst_tvalid", int'(o_tvalid), 0);
        check("rst_tdata", int'(o_tdata), 0);
        check("rst_ferr", int'(framing_error), 0);
        check("rst_ovr", int'(overrun), 0);
        rst = 1'b0;
        idle(4);

        send_frame(16, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(40);
        check("a5_pending", exp_q.size(), 0);

        v0 = vcyc;
        send_frame(16, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(40);
        check("01_pending", exp_q.size(), 0);
        check("01_valid_cycles", vcyc - v0, 1);

        f0 = fe_cnt;
        v0 = vcyc;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(48);
        check("glitch_valid", vcyc - v0, 0);
        check("glitch_ferr", fe_cnt - f0, 0);
        send_frame(16, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(40);
        check("after_glitch_pending", exp_q.size(), 0);

        f0 = fe_cnt;
        v0 = vcyc;
        send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(48);
        check("break_ferr", fe_cnt - f0, 1);
        check("break_valid", vcyc - v0, 0);
        rx = 1'b1;
        idle(20);
        send_frame(16, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(40);
        check("after_break_pending", exp_q.size(), 0);

        rdy_mode = 0;
        idle(3);
        o0 = ov_cnt;
        send_frame(16, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(16, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);
        check("ovr_pulses", ov_cnt - o0, 1);
        check("ovr_tvalid", int'(o_tvalid), 1);
        check("ovr_tdata", int'(o_tdata), 'h011);
        rdy_mode = 1;
        idle(20);
        check("ovr_pending", exp_q.size(), 0);
        check("ovr_tvalid_drained", int'(o_tvalid), 0);

        partial = {1'b1, 1'b0, 8'h55, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            idle(16);
        end
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        check("midrst_tvalid", int'(o_tvalid), 0);
        rst = 1'b0;
        idle(20);
        send_frame(16, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(40);
        check("66_pending", exp_q.size(), 0);

        f0 = fe_cnt;
        o0 = ov_cnt;
        rdy_mode = 2;
        for (int n = 0; n < 12; n++) begin
            div = $urandom_range(4, 24);
            rd  = 8'($urandom);
            rp  = 1'($urandom);
            send_frame(div, rd, rp, 1'b1, 1'b1, 1'b1);
            idle($urandom_range(0, 10));
        end
        rdy_mode = 1;
        idle(100);
        check("rand_pending", exp_q.size(), 0);
        check("rand_ovr", ov_cnt - o0, 0);
        check("rand_ferr", fe_cnt - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
